// File: rtl/i2c_pkg.sv
// ============================================================================
// i2c_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the I2C command sequencer:
//   - transaction mode codes driven on i2c_config (I2C_WAIT .. I2C_READ_DIRECTLY)
//   - bit offsets of the fields inside one 32-bit command-table entry
//   - the sequencer FSM state encoding (also exported on the debug port)
//   - small mode-classification helpers
// ============================================================================
package i2c_pkg;

   // Transaction modes. Anything above I2C_READ_DIRECTLY ends the table.
   localparam logic [7:0] I2C_WAIT             = 8'h00;
   localparam logic [7:0] I2C_WRITE_SINGLE     = 8'h01;
   localparam logic [7:0] I2C_WRITE_CONTINUOUS = 8'h02;
   localparam logic [7:0] I2C_WRITE_DIRECTLY   = 8'h03;
   localparam logic [7:0] I2C_READ_SINGLE      = 8'h04;
   localparam logic [7:0] I2C_READ_CONTINUOUS  = 8'h05;
   localparam logic [7:0] I2C_READ_DIRECTLY    = 8'h06;

   // Entry layout: {mode[7:0], dev[7:0], reg[7:0], data[7:0]}
   localparam int ENTRY_W  = 32;
   localparam int MODE_LSB = 24;
   localparam int DEV_LSB  = 16;
   localparam int REG_LSB  = 8;
   localparam int DATA_LSB = 0;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LOAD      = 4'd1,
      S_ISSUE     = 4'd2,
      S_WAIT_DONE = 4'd3,
      S_CHECK     = 4'd4,
      S_GAP       = 4'd5,
      S_VERIFY    = 4'd6,
      S_NEXT      = 4'd7,
      S_FINISH    = 4'd8,
      S_ERR       = 4'd9
   } seq_state_t;

   function automatic logic is_term_mode(input logic [7:0] m);
      return (m == I2C_WAIT) || (m > I2C_READ_DIRECTLY);
   endfunction

   function automatic logic is_read_mode(input logic [7:0] m);
      return (m >= I2C_READ_SINGLE) && (m <= I2C_READ_DIRECTLY);
   endfunction

endpackage

// File: rtl/i2c_done_sync.sv
// ============================================================================
// i2c_done_sync
// ----------------------------------------------------------------------------
// Brings the i2c_done level from the i2c_clk domain into clk_12m through a
// two-flop synchroniser and produces a one-cycle pulse on its rising edge.
// The pulse is visible in the cycle after the second flop updates, so the
// consumer acts on it three clk_12m edges after the input rises.
//
// Ports:
//   clk_12m  in   system clock
//   rst_n    in   asynchronous active-low reset
//   done_i   in   asynchronous done level
//   rise_o   out  one-cycle pulse on the synchronised rising edge
// ============================================================================
module i2c_done_sync (
   input  logic clk_12m,
   input  logic rst_n,
   input  logic done_i,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= done_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// ============================================================================
// i2c_cmd_sequencer
// ----------------------------------------------------------------------------
// Walks a flattened table of NUM_CMDS command entries and issues one I2C
// transaction per entry to the master logic. Failed transactions (NACK or
// timeout) are re-issued up to RETRY_MAX times; write-type entries are
// followed by GAP_CYC idle cycles (EEPROM write cycle); successful reads are
// presented on rd_data with a rd_valid pulse.
//
// Optional feature (compile-time macro I2C_SEQ_VERIFY_EN):
//   after a successful single write (0x01) and its gap, a single read of the
//   same dev/reg is issued; a read-back that differs from the written byte is
//   treated as a failure that consumes a retry and re-issues the write. The
//   verify read never pulses rd_valid. Without the macro writes simply
//   advance after the gap.
//
// Handshake with the master logic: i2c_go is a one-cycle request while the
// i2c_config/dev/reg/data registers are already stable; they stay stable
// until the next LOAD. The master answers by raising the i2c_done level
// (dropping it again when it sees the next go); i2c_nack and i2c_read_data
// must be held valid while i2c_done is high. Only the synchronised rising
// edge of i2c_done is acted upon.
//
// Ports:
//   clk_12m        in   12 MHz system clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin sequence at entry 0 (IDLE only)
//   cmd_table      in   32*NUM_CMDS flattened entries, entry k at [32k+31:32k]
//   i2c_config     out  mode to master (0x00 while idle)
//   i2c_dev_addr   out  7-bit slave address
//   i2c_reg_addr   out  register address
//   i2c_reg_data   out  write data
//   i2c_go         out  one-cycle transaction request
//   i2c_done       in   transaction-complete level (other clock domain)
//   i2c_nack       in   1 = slave did not acknowledge
//   i2c_read_data  in   read byte
//   rd_data        out  last captured read byte
//   rd_valid       out  one-cycle pulse when rd_data updates
//   rd_idx         out  entry index of rd_data
//   busy           out  high from start accept until FINISH/ERR
//   seq_done       out  sticky: all entries completed
//   seq_error      out  sticky: retries exhausted
//   err_idx        out  failing entry index
//   dbg_state      out  current FSM state (debug)
// ============================================================================
module i2c_cmd_sequencer
   import i2c_pkg::*;
#(
   parameter int NUM_CMDS    = 4,
   parameter int RETRY_MAX   = 3,
   parameter int TIMEOUT_CYC = 24000,
   parameter int GAP_CYC     = 60000
) (
   input  logic                        clk_12m,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [ENTRY_W*NUM_CMDS-1:0] cmd_table,
   output logic [7:0]                  i2c_config,
   output logic [6:0]                  i2c_dev_addr,
   output logic [7:0]                  i2c_reg_addr,
   output logic [7:0]                  i2c_reg_data,
   output logic                        i2c_go,
   input  logic                        i2c_done,
   input  logic                        i2c_nack,
   input  logic [7:0]                  i2c_read_data,
   output logic [7:0]                  rd_data,
   output logic                        rd_valid,
   output logic [3:0]                  rd_idx,
   output logic                        busy,
   output logic                        seq_done,
   output logic                        seq_error,
   output logic [3:0]                  err_idx,
   output seq_state_t                  dbg_state
);

   localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RTY_W   = $clog2(RETRY_MAX + 2);

   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(RETRY_MAX);
   localparam logic [4:0]       LAST_CNT  = 5'(NUM_CMDS);

   seq_state_t       state_q;
   logic [3:0]       idx_q;
   logic [RTY_W-1:0] retry_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       mode_q;
   logic             fail_q;
   logic [7:0]       rbuf_q;

   logic [7:0]       cfg_q;
   logic [6:0]       dev_q;
   logic [7:0]       reg_q;
   logic [7:0]       data_q;
   logic             go_q;
   logic [7:0]       rd_data_q;
   logic             rd_valid_q;
   logic [3:0]       rd_idx_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic [3:0]       err_idx_q;

`ifdef I2C_SEQ_VERIFY_EN
   logic             verify_q;
`endif

   logic             done_rise;
   logic [31:0]      entry;
   logic [7:0]       entry_mode;
   logic             check_fail;
   logic             unused_dev_msb;

   i2c_done_sync u_done_sync (
      .clk_12m (clk_12m),
      .rst_n   (rst_n),
      .done_i  (i2c_done),
      .rise_o  (done_rise)
   );

   // Entry mux built from constant slices so an index beyond NUM_CMDS
   // can never address outside the table port.
   always_comb begin
      entry = '0;
      for (int k = 0; k < NUM_CMDS; k++) begin
         if (idx_q == 4'(k)) entry = cmd_table[ENTRY_W*k +: ENTRY_W];
      end
   end

   assign entry_mode     = entry[MODE_LSB +: 8];
   // Device address bit 7 carries no meaning on a 7-bit bus.
   assign unused_dev_msb = entry[DEV_LSB + 7];

`ifdef I2C_SEQ_VERIFY_EN
   // A verify read fails on NACK/timeout or on a read-back mismatch.
   assign check_fail = fail_q | (verify_q & (rbuf_q != data_q));
`else
   assign check_fail = fail_q;
`endif

   always_ff @(posedge clk_12m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         retry_q    <= '0;
         cnt_q      <= '0;
         mode_q     <= '0;
         fail_q     <= 1'b0;
         rbuf_q     <= '0;
         cfg_q      <= '0;
         dev_q      <= '0;
         reg_q      <= '0;
         data_q     <= '0;
         go_q       <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_idx_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_idx_q  <= '0;
`ifdef I2C_SEQ_VERIFY_EN
         verify_q   <= 1'b0;
`endif
      end else begin
         go_q       <= 1'b0;
         rd_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_LOAD;
                  idx_q     <= '0;
                  retry_q   <= '0;
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  error_q   <= 1'b0;
                  err_idx_q <= '0;
`ifdef I2C_SEQ_VERIFY_EN
                  verify_q  <= 1'b0;
`endif
               end
            end

            S_LOAD: begin
               if (is_term_mode(entry_mode)) begin
                  state_q <= S_FINISH;
                  cfg_q   <= I2C_WAIT;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  mode_q  <= entry_mode;
                  cfg_q   <= entry_mode;
                  dev_q   <= entry[DEV_LSB +: 7];
                  reg_q   <= entry[REG_LSB +: 8];
                  data_q  <= entry[DATA_LSB +: 8];
                  go_q    <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end

            // i2c_go is high for exactly this one cycle.
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT_DONE;
            end

            // A done edge on the last timeout cycle still counts as done.
            S_WAIT_DONE: begin
               if (done_rise) begin
                  fail_q  <= i2c_nack;
                  rbuf_q  <= i2c_read_data;
                  state_q <= S_CHECK;
               end else if (cnt_q == TMO_LAST) begin
                  fail_q  <= 1'b1;
                  state_q <= S_CHECK;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

            S_CHECK: begin
               if (check_fail) begin
                  if (retry_q < RETRY_LIM) begin
                     retry_q <= retry_q + RTY_W'(1);
                     go_q    <= 1'b1;
                     state_q <= S_ISSUE;
`ifdef I2C_SEQ_VERIFY_EN
                     // A failed verify re-issues the original write.
                     cfg_q    <= mode_q;
                     verify_q <= 1'b0;
`endif
                  end else begin
                     state_q   <= S_ERR;
                     err_idx_q <= idx_q;
                     error_q   <= 1'b1;
                     busy_q    <= 1'b0;
                     cfg_q     <= I2C_WAIT;
                  end
               end else
`ifdef I2C_SEQ_VERIFY_EN
               if (verify_q) begin
                  verify_q <= 1'b0;
                  state_q  <= S_NEXT;
               end else
`endif
               if (is_read_mode(mode_q)) begin
                  rd_data_q  <= rbuf_q;
                  rd_idx_q   <= idx_q;
                  rd_valid_q <= 1'b1;
                  state_q    <= S_NEXT;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_GAP;
               end
            end

            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
`ifdef I2C_SEQ_VERIFY_EN
                  state_q <= (mode_q == I2C_WRITE_SINGLE) ? S_VERIFY : S_NEXT;
`else
                  state_q <= S_NEXT;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end

`ifdef I2C_SEQ_VERIFY_EN
            S_VERIFY: begin
               cfg_q    <= I2C_READ_SINGLE;
               verify_q <= 1'b1;
               go_q     <= 1'b1;
               state_q  <= S_ISSUE;
            end
`endif

            S_NEXT: begin
               retry_q <= '0;
               if (({1'b0, idx_q} + 5'd1) == LAST_CNT) begin
                  state_q <= S_FINISH;
                  cfg_q   <= I2C_WAIT;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 4'd1;
                  state_q <= S_LOAD;
               end
            end

            S_FINISH: state_q <= S_IDLE;
            S_ERR:    state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign i2c_config   = cfg_q;
   assign i2c_dev_addr = dev_q;
   assign i2c_reg_addr = reg_q;
   assign i2c_reg_data = data_q;
   assign i2c_go       = go_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign rd_idx       = rd_idx_q;
   assign busy         = busy_q;
   assign seq_done     = done_q;
   assign seq_error    = error_q;
   assign err_idx      = err_idx_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: table vectors, hand-written corner sequences,
// and randomized tables checked against a transaction-level model.
module tb_i2c_cmd_sequencer;
   import i2c_pkg::*;

   localparam int NUM  = 4;
   localparam int RMAX = 3;
   localparam int TMO  = 50;
   localparam int GAP  = 10;
`ifdef I2C_SEQ_VERIFY_EN
   localparam int VX = 1;
`else
   localparam int VX = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk_12m = 1'b0;
   logic rst_n;
   always #5 clk_12m = ~clk_12m;

   logic             start;
   logic [32*NUM-1:0] cmd_table;
   logic [7:0]       i2c_config;
   logic [6:0]       i2c_dev_addr;
   logic [7:0]       i2c_reg_addr;
   logic [7:0]       i2c_reg_data;
   logic             i2c_go;
   logic             i2c_done;
   logic             i2c_nack;
   logic [7:0]       i2c_read_data;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic [3:0]       rd_idx;
   logic             busy;
   logic             seq_done;
   logic             seq_error;
   logic [3:0]       err_idx;
   seq_state_t       dbg_state;

   i2c_cmd_sequencer #(
      .NUM_CMDS(NUM), .RETRY_MAX(RMAX), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)
   ) dut (
      .clk_12m(clk_12m), .rst_n(rst_n), .start(start), .cmd_table(cmd_table),
      .i2c_config(i2c_config), .i2c_dev_addr(i2c_dev_addr),
      .i2c_reg_addr(i2c_reg_addr), .i2c_reg_data(i2c_reg_data),
      .i2c_go(i2c_go), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
      .i2c_read_data(i2c_read_data), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_idx(rd_idx), .busy(busy), .seq_done(seq_done), .seq_error(seq_error),
      .err_idx(err_idx), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] go_log[$];       // observed {cfg, 0, dev, reg, data} per go
   logic [11:0] got_rd_q[$];     // observed {rd_idx, rd_data}
   logic [31:0] exp_q[$];        // model transactions
   logic [11:0] exp_rd_q[$];     // model read events
   bit          m_done, m_err;
   logic [3:0]  m_err_idx;
   bit          plan[64];        // NACK decision per go within one run
   int          run_go_idx = 0;
   int          go_cnt = 0;
   bit          hold_done = 0;
   logic [7:0]  rdov_q[$];       // read-data overrides for the slave model
   logic [7:0]  mem[32768];      // slave register space, index {dev, reg}
   logic [7:0]  mm[32768];       // model copy

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ent(input logic [7:0] m, input logic [7:0] d,
                                      input logic [7:0] r, input logic [7:0] w);
      return {m, d, r, w};
   endfunction

   function automatic logic [127:0] mk(input logic [31:0] e0, input logic [31:0] e1,
                                      input logic [31:0] e2, input logic [31:0] e3);
      return {e3, e2, e1, e0};
   endfunction

   // ---------------- slave / master-logic model ----------------
   initial begin : responder
      logic [31:0] t;
      bit          nk;
      int          lat;
      i2c_done = 1'b0; i2c_nack = 1'b0; i2c_read_data = 8'h00;
      forever begin
         @(negedge clk_12m);
         if (rst_n && i2c_go) begin
            t = {i2c_config, 1'b0, i2c_dev_addr, i2c_reg_addr, i2c_reg_data};
            go_log.push_back(t);
            go_cnt++;
            i2c_done = 1'b0;
            nk = plan[run_go_idx % 64];
            run_go_idx++;
            lat = $urandom_range(1, 5);
            repeat (lat) @(negedge clk_12m);
            if (!hold_done) begin
               i2c_nack = nk;
               if (t[31:24] >= 8'h04 && t[31:24] <= 8'h06) begin
                  if (rdov_q.size() > 0) i2c_read_data = rdov_q.pop_front();
                  else i2c_read_data = mem[t[22:8]];
               end else begin
                  if (!nk) mem[t[22:8]] = t[7:0];
                  i2c_read_data = 8'($urandom_range(0, 255));
               end
               i2c_done = 1'b1;
            end
         end
      end
   end

   initial begin : rd_monitor
      forever begin
         @(negedge clk_12m);
         if (rst_n && rd_valid) got_rd_q.push_back({rd_idx, rd_data});
      end
   end

   // ---------------- reference model ----------------
   // Walks the table entry by entry, one transaction per attempt.
   task automatic model_run(input logic [127:0] tbl);
      int g, tries;
      bit fail, ok;
      logic [7:0]  mode, rg, dt, rdv;
      logic [6:0]  dv;
      logic [14:0] a;
      exp_q.delete(); exp_rd_q.delete();
      m_done = 0; m_err = 0; m_err_idx = 0; g = 0; rdv = 0;
      for (int k = 0; k < NUM; k++) begin
         mode = tbl[32*k+24 +: 8];
         dv   = tbl[32*k+16 +: 7];
         rg   = tbl[32*k+8 +: 8];
         dt   = tbl[32*k +: 8];
         a    = {dv, rg};
         if (mode == 8'h00 || mode > 8'h06) break;
         tries = 0; ok = 0;
         while (!ok && !m_err) begin
            exp_q.push_back({mode, 1'b0, dv, rg, dt});
            fail = plan[g % 64]; g++;
            if (!fail && mode >= 8'h04) rdv = mm[a];
            if (!fail && mode <= 8'h03) mm[a] = dt;
`ifdef I2C_SEQ_VERIFY_EN
            if (!fail && mode == 8'h01) begin
               exp_q.push_back({8'h04, 1'b0, dv, rg, dt});
               fail = plan[g % 64]; g++;
               if (!fail && mm[a] != dt) fail = 1;
            end
`endif
            if (!fail) ok = 1;
            else if (tries == RMAX) begin m_err = 1; m_err_idx = 4'(k); end
            else tries++;
         end
         if (m_err) break;
         if (mode >= 8'h04) exp_rd_q.push_back({4'(k), rdv});
      end
      m_done = !m_err;
   endtask

   // ---------------- driver ----------------
   task automatic run_table(input logic [127:0] tbl, input int budget);
      bit ended;
      cmd_table = tbl;
      go_log.delete(); got_rd_q.delete(); run_go_idx = 0;
      @(negedge clk_12m); start = 1'b1;
      @(negedge clk_12m); start = 1'b0;
      ended = 0;
      for (int i = 0; i < budget; i++) begin
         if ((seq_done || seq_error) && !busy) begin ended = 1; break; end
         @(negedge clk_12m);
      end
      check("sequence_ends", 64'(ended), 64'd1);
      repeat (2) @(negedge clk_12m);
   endtask

   typedef struct {
      string        name;
      logic [127:0] tbl;
      logic [15:0]  nack_pat;
      int           exp_gos;
      int           exp_rds;
      logic [7:0]   exp_rd_data;
      logic [3:0]   exp_rd_idx;
      bit           exp_done;
      bit           exp_err;
      logic [3:0]   exp_err_idx;
   } vec_t;

   vec_t vecs[7];

   initial begin : main
      int   c0, n;
      bit   ended;
      logic [127:0] rt;

      vecs[0] = '{"write_then_read", mk(ent(8'h01,8'h50,8'h00,8'h11), ent(8'h04,8'h50,8'h00,8'h00), 0, 0),
                  16'h0000, 2+VX, 1, 8'h11, 4'd1, 1, 0, 4'd0};
      vecs[1] = '{"nack_twice_then_ack", mk(ent(8'h01,8'h50,8'h01,8'hA5), 0, 0, 0),
                  16'h0003, 3+VX, 0, 8'h00, 4'd0, 1, 0, 4'd0};
      vecs[2] = '{"retries_exhausted", mk(ent(8'h03,8'h50,8'h02,8'h33), ent(8'h02,8'h51,8'h03,8'h44), 0, 0),
                  16'h001E, 5, 0, 8'h00, 4'd0, 0, 1, 4'd1};
      vecs[3] = '{"immediate_terminator", mk(0, 0, 0, 0), 16'h0000, 0, 0, 8'h00, 4'd0, 1, 0, 4'd0};
      vecs[4] = '{"full_table", mk(ent(8'h04,8'h20,8'h10,8'h00), ent(8'h05,8'h21,8'h11,8'h00),
                                   ent(8'h06,8'h22,8'h12,8'h00), ent(8'h03,8'h23,8'h13,8'h77)),
                  16'h0000, 4, 3, 8'h30, 4'd2, 1, 0, 4'd0};
      vecs[5] = '{"invalid_mode_terminates", mk(ent(8'h02,8'h30,8'h00,8'h01), ent(8'h07,8'h31,8'h00,8'h00),
                                                ent(8'h04,8'h30,8'h00,8'h00), 0),
                  16'h0000, 1, 0, 8'h00, 4'd0, 1, 0, 4'd0};
      vecs[6] = '{"read_nack_once", mk(ent(8'h05,8'hC0,8'h07,8'h00), 0, 0, 0),
                  16'h0001, 2, 1, 8'h47, 4'd0, 1, 0, 4'd0};

      // Slave register contents start as reg ^ dev.
      for (int i = 0; i < 32768; i++) mem[i] = 8'(i) ^ 8'(i >> 8);

      // ---- reset ----
      rst_n = 1'b0; start = 1'b0; cmd_table = '0;
      repeat (3) @(negedge clk_12m);
      check("reset_outputs", 64'({i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, i2c_go,
                                  rd_data, rd_valid, rd_idx, busy, seq_done, seq_error, err_idx}), 64'd0);
      check("reset_state", 64'(dbg_state), 64'(S_IDLE));
      rst_n = 1'b1;
      repeat (2) @(negedge clk_12m);

      // ---- table vectors ----
      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < 64; i++) plan[i] = (i < 16) ? vecs[v].nack_pat[i] : 1'b0;
         run_table(vecs[v].tbl, 3000);
         check({vecs[v].name, "_gos"}, 64'(go_log.size()), 64'(vecs[v].exp_gos));
         check({vecs[v].name, "_rds"}, 64'(got_rd_q.size()), 64'(vecs[v].exp_rds));
         if (vecs[v].exp_rds > 0 && got_rd_q.size() > 0)
            check({vecs[v].name, "_last_rd"}, 64'(got_rd_q[$]), 64'({vecs[v].exp_rd_idx, vecs[v].exp_rd_data}));
         check({vecs[v].name, "_done"}, 64'(seq_done), 64'(vecs[v].exp_done));
         check({vecs[v].name, "_error"}, 64'(seq_error), 64'(vecs[v].exp_err));
         check({vecs[v].name, "_err_idx"}, 64'(err_idx), 64'(vecs[v].exp_err_idx));
         check({vecs[v].name, "_idle_cfg_busy"}, 64'({i2c_config, busy}), 64'd0);
      end

      // ---- timeout: done never arrives ----
      for (int i = 0; i < 64; i++) plan[i] = 1'b0;
      hold_done = 1;
      cmd_table = mk(ent(8'h01,8'h50,8'h00,8'h11), 0, 0, 0);
      go_log.delete(); run_go_idx = 0;
      @(negedge clk_12m); start = 1'b1;
      @(negedge clk_12m); start = 1'b0;
      n = -1;
      for (int i = 0; i < 1000; i++) begin
         if (seq_error || seq_done) begin n = i; break; end
         @(negedge clk_12m);
      end
      check("timeout_cycles_in_range", 64'(n >= 200 && n <= 215), 64'd1);
      check("timeout_gos", 64'(go_log.size()), 64'd4);
      check("timeout_flags", 64'({seq_done, seq_error, err_idx}), 64'({1'b0, 1'b1, 4'd0}));
      repeat (3) @(negedge clk_12m);

      // ---- start latency, then reset while in WAIT_DONE ----
      cmd_table = mk(ent(8'h04,8'h50,8'h00,8'h00), 0, 0, 0);
      c0 = go_cnt;
      @(negedge clk_12m); start = 1'b1;
      @(negedge clk_12m); start = 1'b0;
      check("go_not_yet_cycle1", 64'(i2c_go), 64'd0);
      check("busy_after_accept", 64'(busy), 64'd1);
      @(negedge clk_12m);
      check("go_at_cycle2", 64'(i2c_go), 64'd1);
      repeat (4) @(negedge clk_12m);
      check("in_wait_done", 64'(dbg_state), 64'(S_WAIT_DONE));
      check("outputs_hold_in_wait", 64'({i2c_config, i2c_dev_addr, i2c_reg_addr}), 64'({8'h04, 7'h50, 8'h00}));
      rst_n = 1'b0;
      #1;
      check("midseq_reset_outputs", 64'({i2c_config, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, i2c_go,
                                         rd_data, rd_valid, rd_idx, busy, seq_done, seq_error, err_idx}), 64'd0);
      @(negedge clk_12m); rst_n = 1'b1;
      repeat (8) @(negedge clk_12m);
      check("no_go_after_reset", 64'(go_cnt - c0), 64'd1);
      check("idle_after_reset", 64'(dbg_state), 64'(S_IDLE));
      hold_done = 0;

      // ---- start pulses while busy are ignored ----
      cmd_table = mk(ent(8'h01,8'h50,8'h00,8'h11), ent(8'h04,8'h50,8'h00,8'h00), 0, 0);
      go_log.delete(); got_rd_q.delete(); run_go_idx = 0;
      @(negedge clk_12m); start = 1'b1;
      @(negedge clk_12m); start = 1'b0;
      ended = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_12m);
         if (seq_done && !busy) begin ended = 1; break; end
         start = busy && (i % 5 == 2);
      end
      start = 1'b0;
      check("busy_start_ends", 64'(ended), 64'd1);
      check("busy_start_gos", 64'(go_log.size()), 64'(2 + VX));
      check("busy_start_rds", 64'(got_rd_q.size()), 64'd1);
      repeat (3) @(negedge clk_12m);

`ifdef I2C_SEQ_VERIFY_EN
      // ---- verify: first read-back mismatches, second matches ----
      rdov_q.push_back(8'h22);
      rdov_q.push_back(8'h11);
      run_table(mk(ent(8'h01,8'h50,8'h00,8'h11), 0, 0, 0), 3000);
      check("verify_gos", 64'(go_log.size()), 64'd4);
      if (go_log.size() == 4) begin
         check("verify_tx0", 64'(go_log[0]), 64'h0150_0011);
         check("verify_tx1", 64'(go_log[1]), 64'h0450_0011);
         check("verify_tx2", 64'(go_log[2]), 64'h0150_0011);
         check("verify_tx3", 64'(go_log[3]), 64'h0450_0011);
      end
      check("verify_no_rd_valid", 64'(got_rd_q.size()), 64'd0);
      check("verify_done", 64'({seq_done, seq_error}), 64'b10);
`endif

      // ---- randomized tables against the model ----
      for (int r = 0; r < 30; r++) begin
         for (int k = 0; k < NUM; k++) begin
            logic [7:0] m;
            n = $urandom_range(0, 9);
            m = (n == 0) ? ((n + r) % 2 == 0 ? 8'h00 : 8'(8'h07 + $urandom_range(0, 200)))
                         : 8'($urandom_range(1, 6));
            rt[32*k +: 32] = ent(m, {1'($urandom_range(0, 1)), 7'(8'h50 + $urandom_range(0, 3))},
                                 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
         end
         for (int i = 0; i < 64; i++) plan[i] = ($urandom_range(0, 3) == 0);
         mm = mem;
         model_run(rt);
         run_table(rt, 4000);
         check("rand_gos", 64'(go_log.size()), 64'(exp_q.size()));
         for (int i = 0; i < exp_q.size() && i < go_log.size(); i++)
            check("rand_tx", 64'(go_log[i]), 64'(exp_q[i]));
         check("rand_rds", 64'(got_rd_q.size()), 64'(exp_rd_q.size()));
         for (int i = 0; i < exp_rd_q.size() && i < got_rd_q.size(); i++)
            check("rand_rd", 64'(got_rd_q[i]), 64'(exp_rd_q[i]));
         check("rand_flags", 64'({seq_done, seq_error}), 64'({m_done, m_err}));
         if (m_err) check("rand_err_idx", 64'(err_idx), 64'(m_err_idx));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
